// File: rtl/dmem_ctrl_pkg.sv
// Shared types and width helpers for the M-stage data memory access controller.
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  localparam logic [1:0] W_BYTE  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  function automatic logic [3:0] width_bytes(input logic [1:0] w);
    case (w)
      W_BYTE:  return 4'd1;
      W_HALF:  return 4'd2;
      W_WORD:  return 4'd4;
      W_DWORD: return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data memory port: req/gnt request channel plus rvalid read-return channel.
interface dmem_access_ctrl_if #(parameter int N = 64);
  logic          mem_req;
  logic          mem_we;
  logic [N-1:0]  mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_be;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/dmem_align.sv
// Lane alignment for one access: byte enables over two beats, shifted store data, split flag.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  width,
  input  logic [63:0] wdata,
  output logic [15:0] be16,
  output logic [63:0] wbeat0,
  output logic [63:0] wbeat1,
  output logic        split
);

  logic [3:0] nbytes;

  assign nbytes = width_bytes(width);
  assign split  = ({2'b00, off} + {1'b0, nbytes}) > 5'd8;
  assign be16   = ((16'd1 << nbytes) - 16'd1) << off;
  assign wbeat0 = wdata << {off, 3'b000};
  // With zero offset nothing spills into the second beat.
  assign wbeat1 = (off == 3'd0) ? '0 : (wdata >> {(4'd8 - {1'b0, off}), 3'b000});

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage load/store sequencer: issues one or two aligned beats, merges read data, stalls until done.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  input  logic [2:0]   req_width,
  output logic         stall_M,
  output logic         rdone_M,
  output logic [N-1:0] rdata_M,
  dmem_access_ctrl_if.master mem
);

  state_t        state_q, state_d;
  logic          we_q, split_q;
  logic [2:0]    off_q;
  logic [7:0]    be_hi_q;
  logic [63:0]   wdata_hi_q;
  logic [63:0]   beat0_q, beat1_q;
  logic [15:0]   be16_w;
  logic [63:0]   wbeat0_w, wbeat1_w;
  logic          split_w;
  logic [127:0]  merged_w;
  logic          unused_width_msb;

  assign unused_width_msb = req_width[2];

  dmem_align u_align (
    .off    (req_addr[2:0]),
    .width  (req_width[1:0]),
    .wdata  (req_wdata[63:0]),
    .be16   (be16_w),
    .wbeat0 (wbeat0_w),
    .wbeat1 (wbeat1_w),
    .split  (split_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE0;
      ISSUE0:  if (mem.mem_gnt) state_d = we_q ? (split_q ? ISSUE1 : RESP) : WAIT0;
      WAIT0:   if (mem.mem_rvalid) state_d = split_q ? ISSUE1 : RESP;
      ISSUE1:  if (mem.mem_gnt) state_d = we_q ? RESP : WAIT1;
      WAIT1:   if (mem.mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_M  = ((state_q == IDLE) && req_valid) || (state_q == ISSUE0) ||
                    (state_q == WAIT0) || (state_q == ISSUE1) || (state_q == WAIT1);
  assign rdone_M  = (state_q == RESP);
  // beat1_q is cleared on accept, so unsplit loads merge against zero.
  assign merged_w = {beat1_q, beat0_q} >> {off_q, 3'b000};
  assign rdata_M  = N'(merged_w[63:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      split_q        <= 1'b0;
      off_q          <= '0;
      be_hi_q        <= '0;
      wdata_hi_q     <= '0;
      beat0_q        <= '0;
      beat1_q        <= '0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      mem.mem_be     <= '0;
    end else begin
      state_q     <= state_d;
      mem.mem_req <= (state_d == ISSUE0) || (state_d == ISSUE1);
      if ((state_q == IDLE) && req_valid) begin
        we_q          <= req_write;
        split_q       <= split_w;
        off_q         <= req_addr[2:0];
        be_hi_q       <= be16_w[15:8];
        wdata_hi_q    <= wbeat1_w;
        beat0_q       <= '0;
        beat1_q       <= '0;
        mem.mem_we    <= req_write;
        mem.mem_addr  <= {req_addr[N-1:3], 3'b000};
        mem.mem_be    <= be16_w[7:0];
        mem.mem_wdata <= wbeat0_w;
      end
      // Second beat: next aligned address, wrapping naturally at 2^N.
      if ((state_d == ISSUE1) && (state_q != ISSUE1)) begin
        mem.mem_addr  <= mem.mem_addr + N'(8);
        mem.mem_be    <= be_hi_q;
        mem.mem_wdata <= wdata_hi_q;
      end
      if ((state_q == WAIT0) && mem.mem_rvalid) beat0_q <= mem.mem_rdata;
      if ((state_q == WAIT1) && mem.mem_rvalid) beat1_q <= mem.mem_rdata;
    end
  end

endmodule
